vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 98 +++++++++
 tb/tb_vga_timing_gen.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// Free-running pixel/line counters with registered sync, blanking and
// start-of-line/frame strobes. Every strobe is decoded from the next-count
// values, so it lines up with the DrawX/DrawY value it describes.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_LO = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_HI = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_SYNC_LO = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_HI = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    // Half-open window test: lo <= v < hi.
    function automatic logic in_window(input logic [9:0] v,
                                       input logic [9:0] lo,
                                       input logic [9:0] hi);
        return (v >= lo) && (v < hi);
    endfunction

    logic       h_wrap;
    logic       v_wrap;
    logic       frame_wrap;
    logic [9:0] x_p0;
    logic [9:0] y_p0;

    // Next-count values: the registered outputs are all decoded from these.
    always_comb begin
        h_wrap     = (DrawX == H_LAST);
        v_wrap     = (DrawY == V_LAST);
        frame_wrap = h_wrap && v_wrap;
        x_p0       = h_wrap ? 10'd0 : DrawX + 10'd1;
        y_p0       = DrawY;
        if (h_wrap) begin
            y_p0 = v_wrap ? 10'd0 : DrawY + 10'd1;
        end
    end

    // Raster counters and completed-frame counter.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            DrawX       <= 10'd0;
            DrawY       <= 10'd0;
            frame_count <= 8'd0;
        end else begin
            DrawX <= x_p0;
            DrawY <= y_p0;
            if (frame_wrap) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

    // Sync, blanking and strobes decoded from the next counts so they land
    // in the same cycle as the position they describe. The reset state at
    // (0,0) never produced a strobe, so the first frame has no start pulse.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hs          <= 1'b1;
            vs          <= 1'b1;
            blank       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hs          <= !in_window(x_p0, H_SYNC_LO, H_SYNC_HI);
            vs          <= !in_window(y_p0, V_SYNC_LO, V_SYNC_HI);
            blank       <= (x_p0 < H_VIS_END) && (y_p0 < V_VIS_END);
            line_start  <= h_wrap;
            frame_start <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: a small-raster instance (so 256+ frames fit
// in a short run) and a default 640x480 instance share clock and reset.
// Expected values come from the elapsed-cycle count since reset release.
module tb_vga_timing_gen;

    // Small raster: 16 x 11 = 176 cycles per frame.
    localparam int S_HV = 8, S_HF = 2, S_HS = 3, S_HB = 3;
    localparam int S_VV = 6, S_VF = 1, S_VS = 2, S_VB = 2;
    localparam int S_FT = (S_HV + S_HF + S_HS + S_HB) * (S_VV + S_VF + S_VS + S_VB);

    logic vga_clk = 1'b0;
    logic reset_n = 1'b0;

    logic [9:0] s_x, s_y, d_x, d_y;
    logic       s_hs, s_vs, s_bl, s_ls, s_fs;
    logic       d_hs, d_vs, d_bl, d_ls, d_fs;
    logic [7:0] s_fc, d_fc;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint t        = 0;   // clock edges since reset release; 0 = reset state

    // Default-raster per-line run-length bookkeeping.
    bit     full_line = 1'b0;
    int     hs_low_cnt = 0;
    int     bl_low_cnt = 0;

    always #5 vga_clk = ~vga_clk;

    vga_timing_gen #(
        .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
    ) dut_small (
        .vga_clk(vga_clk), .reset_n(reset_n),
        .DrawX(s_x), .DrawY(s_y), .hs(s_hs), .vs(s_vs), .blank(s_bl),
        .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
    );

    vga_timing_gen dut_dflt (
        .vga_clk(vga_clk), .reset_n(reset_n),
        .DrawX(d_x), .DrawY(d_y), .hs(d_hs), .vs(d_vs), .blank(d_bl),
        .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0d, time %0t)", tag, got, exp, t, $time);
        end
    endtask

    // Reference: position is elapsed cycles modulo the raster geometry.
    task automatic check_dut(input string nm,
                             input int hv, input int hf, input int hsy, input int hb,
                             input int vv, input int vf, input int vsy, input int vb,
                             input logic [9:0] x, input logic [9:0] y,
                             input logic h, input logic v, input logic b,
                             input logic ls, input logic fs, input logic [7:0] fc);
        int     ht, vt;
        longint ft;
        int     ex, ey, efc;
        bit     eh, ev, eb, els, efs;
        ht = hv + hf + hsy + hb;
        vt = vv + vf + vsy + vb;
        ft = longint'(ht) * longint'(vt);
        if (t == 0) begin
            ex = 0; ey = 0; efc = 0;
            eh = 1; ev = 1; eb = 0; els = 0; efs = 0;
        end else begin
            ex  = int'(t % ht);
            ey  = int'((t / ht) % vt);
            efc = int'((t / ft) % 256);
            eh  = !((ex >= hv + hf) && (ex < hv + hf + hsy));
            ev  = !((ey >= vv + vf) && (ey < vv + vf + vsy));
            eb  = (ex < hv) && (ey < vv);
            els = (ex == 0);
            efs = (ex == 0) && (ey == 0);
        end
        check({nm, ".DrawX"},       32'(x),  32'(ex));
        check({nm, ".DrawY"},       32'(y),  32'(ey));
        check({nm, ".hs"},          32'(h),  32'(eh));
        check({nm, ".vs"},          32'(v),  32'(ev));
        check({nm, ".blank"},       32'(b),  32'(eb));
        check({nm, ".line_start"},  32'(ls), 32'(els));
        check({nm, ".frame_start"}, 32'(fs), 32'(efs));
        check({nm, ".frame_count"}, 32'(fc), 32'(efc));
    endtask

    task automatic check_all();
        int xd, yd;
        check_dut("small", S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB,
                  s_x, s_y, s_hs, s_vs, s_bl, s_ls, s_fs, s_fc);
        check_dut("dflt", 640, 16, 96, 48, 480, 10, 2, 33,
                  d_x, d_y, d_hs, d_vs, d_bl, d_ls, d_fs, d_fc);
        if (t == 0) begin
            full_line = 1'b0;
        end else begin
            xd = int'(t % 800);
            yd = int'((t / 800) % 525);
            if (xd == 0) begin
                full_line  = 1'b1;
                hs_low_cnt = 0;
                bl_low_cnt = 0;
            end
            if (!d_hs) hs_low_cnt++;
            if (!d_bl) bl_low_cnt++;
            if (xd == 799 && full_line && yd < 480) begin
                check("dflt.hs_low_run",    32'(hs_low_cnt), 32'd96);
                check("dflt.blank_low_run", 32'(bl_low_cnt), 32'd160);
            end
        end
    endtask

    // Advance n clock edges, sampling outputs on each falling edge.
    task automatic run_cycles(input int n);
        repeat (n) begin
            @(posedge vga_clk);
            if (reset_n) t++;
            @(negedge vga_clk);
            check_all();
        end
    endtask

    // Assert reset between clock edges and confirm it acts without an edge.
    task automatic async_reset_pulse();
        #($urandom_range(1, 3));
        reset_n = 1'b0;
        t = 0;
        #1;
        check_all();
        run_cycles(int'($urandom_range(1, 4)));
        reset_n = 1'b1;
    endtask

    initial begin
        run_cycles(3);
        reset_n = 1'b1;

        // Long run past 256 small frames so frame_count wraps.
        run_cycles(257 * S_FT + 40);

        // Targeted reset inside the small raster's hsync window.
        async_reset_pulse();
        run_cycles(3 * 16 + 11);
        async_reset_pulse();

        // Randomized mid-frame resets.
        for (int i = 0; i < 6; i++) begin
            run_cycles(int'($urandom_range(20, 3000)));
            async_reset_pulse();
        end
        run_cycles(900);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
